serial_out_arbiter: RTL and testbench

SERIAL_OUT_ARBITER -- requirements
Module: serial_out_arbiter

---
 rtl/serial_out_pkg.sv | 29 ++
 rtl/serial_out_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/serial_out_arbiter.sv | 146 ++++++++++++++
 tb/tb_serial_out_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_out_pkg.sv
// Shared types and defaults for the serial output arbiter: FSM state encoding,
// default field widths and elaboration-time width helpers.
package serial_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int DEF_SIZE_A = 7;
  localparam int DEF_SIZE_D = 8;
  // Frame on the wire: '0' + A + 'Z' + D + 'Z' + '0'
  localparam int DEF_FRAME_LEN = 1 + DEF_SIZE_A + 1 + DEF_SIZE_D + 1 + 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_out_arbiter_if.sv
// Requester-side bus of the serial output arbiter: request/field inputs,
// acknowledge and the registered frame outputs toward the serial buffer.
interface serial_out_arbiter_if
  import serial_out_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SIZE_A  = DEF_SIZE_A,
  parameter int SIZE_D  = DEF_SIZE_D
);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic                       enable;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*SIZE_A-1:0]  req_a;
  logic [NUM_REQ*SIZE_D-1:0]  req_d;
  logic [NUM_REQ-1:0]         ack;
  logic                       go;
  logic [SIZE_A-1:0]          a_out;
  logic [SIZE_D-1:0]          d_out;
  logic [IDX_W-1:0]           grant_id;
  logic                       busy;
  logic                       frame_done;

  modport master (
    output enable, req, req_a, req_d,
    input  ack, go, a_out, d_out, grant_id, busy, frame_done
  );

  modport slave (
    input  enable, req, req_a, req_d,
    output ack, go, a_out, d_out, grant_id, busy, frame_done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// ascending with wrap-around.
module rr_arbiter
  import serial_out_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/serial_out_arbiter.sv
// Shares one serial output buffer among NUM_REQ requesters: round-robin grant,
// field capture, go/ack pulse, frame timing and inter-frame gap.
module serial_out_arbiter
  import serial_out_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SIZE_A     = DEF_SIZE_A,
  parameter int SIZE_D     = DEF_SIZE_D,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  serial_out_arbiter_if.slave  bus
);

  localparam int IDX_W   = idx_width(NUM_REQ);
  localparam int CNT_MAX = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t             state, state_nx;
  cnt_t               cnt, cnt_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [IDX_W-1:0]   grant_id_q, grant_id_nx;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_any;
  logic [NUM_REQ-1:0] ack_q, ack_nx;
  logic               go_q, go_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;
  logic [SIZE_A-1:0]  a_q, a_nx;
  logic [SIZE_D-1:0]  d_q, d_nx;

  logic [SIZE_A-1:0]  a_field [NUM_REQ];
  logic [SIZE_D-1:0]  d_field [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fields
    assign a_field[g] = bus.req_a[g*SIZE_A +: SIZE_A];
    assign d_field[g] = bus.req_d[g*SIZE_D +: SIZE_D];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (bus.req),
    .rr_ptr    (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any_grant (win_any)
  );

  // Next-state and next-output logic; every output is registered, so the
  // pulses are decided one cycle ahead from the state being entered.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rr_ptr_nx   = rr_ptr;
    grant_id_nx = grant_id_q;
    a_nx        = a_q;
    d_nx        = d_q;
    ack_nx      = '0;
    go_nx       = 1'b0;
    done_nx     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.enable && win_any) begin
          state_nx    = ST_LOAD;
          go_nx       = 1'b1;
          ack_nx      = win_onehot;
          grant_id_nx = win_idx;
          a_nx        = a_field[win_idx];
          d_nx        = d_field[win_idx];
          rr_ptr_nx   = (int'(win_idx) == NUM_REQ - 1) ? '0
                                                       : IDX_W'(int'(win_idx) + 1);
        end
      end
      ST_LOAD: begin
        state_nx = ST_SEND;
        cnt_nx   = cnt_t'(FRAME_LEN);
      end
      ST_SEND: begin
        if (cnt == cnt_t'(1)) begin
          state_nx = ST_GAP;
          cnt_nx   = cnt_t'(GAP_CYCLES);
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - cnt_t'(1);
        end
      end
      ST_GAP: begin
        if (cnt == cnt_t'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - cnt_t'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      grant_id_q <= '0;
      a_q        <= '0;
      d_q        <= '0;
      ack_q      <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rr_ptr     <= rr_ptr_nx;
      grant_id_q <= grant_id_nx;
      a_q        <= a_nx;
      d_q        <= d_nx;
      ack_q      <= ack_nx;
      go_q       <= go_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.go         = go_q;
  assign bus.a_out      = a_q;
  assign bus.d_out      = d_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_serial_out_arbiter.sv
// Bench for serial_out_arbiter: directed scenarios plus randomized requester
// traffic checked against a frame-timeline reference model.
module tb_serial_out_arbiter;
  import serial_out_pkg::*;

  localparam int NR = 4;
  localparam int SA = 7;
  localparam int SD = 8;
  localparam int FL = 19;
  localparam int GC = 2;
  localparam int PERIOD = FL + GC + 2;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  serial_out_arbiter_if #(.NUM_REQ(NR), .SIZE_A(SA), .SIZE_D(SD)) bus ();

  serial_out_arbiter #(
    .NUM_REQ(NR), .SIZE_A(SA), .SIZE_D(SD), .FRAME_LEN(FL), .GAP_CYCLES(GC)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: m_t = cycles elapsed since the grant decision (0 = idle).
  int          m_t, m_ptr, m_win;
  logic [SA-1:0] m_a;
  logic [SD-1:0] m_d;
  logic          exp_go, exp_fd, exp_busy;
  logic [NR-1:0] exp_ack;

  task automatic model_reset();
    m_t = 0; m_ptr = 0; m_win = 0; m_a = '0; m_d = '0;
    exp_go = 1'b0; exp_fd = 1'b0; exp_busy = 1'b0; exp_ack = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    cyc++;
    if (m_t == 0 || m_t > 1 + FL + GC) begin
      m_t = 0;
      if (bus.enable && bus.req != '0) begin
        for (int k = 0; k < NR; k++) begin
          if (bus.req[(m_ptr + k) % NR]) begin
            m_win = (m_ptr + k) % NR;
            break;
          end
        end
        m_a   = SA'(bus.req_a >> (m_win * SA));
        m_d   = SD'(bus.req_d >> (m_win * SD));
        m_ptr = (m_win + 1) % NR;
        m_t   = 1;
      end
    end else begin
      m_t++;
    end
    #1;
    exp_go   = (m_t == 1);
    exp_ack  = exp_go ? (NR'(1) << m_win) : '0;
    exp_fd   = (m_t == 2 + FL);
    exp_busy = (m_t >= 1 && m_t <= 1 + FL + GC);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.req = '0; bus.req_a = '0; bus.req_d = '0;
    repeat (3) @(posedge clk_in);
    #1;
    total++; if ({bus.go, bus.ack, bus.frame_done, bus.busy} !== '0) begin bad++;
      $display("FAIL reset_ctrl got go=%0b ack=%b fd=%0b busy=%0b want all 0", bus.go, bus.ack, bus.frame_done, bus.busy); end
    total++; if (bus.a_out !== '0) begin bad++; $display("FAIL reset_a got=%h want=0", bus.a_out); end
    total++; if (bus.d_out !== '0) begin bad++; $display("FAIL reset_d got=%h want=0", bus.d_out); end
    total++; if (bus.grant_id !== '0) begin bad++; $display("FAIL reset_gid got=%0d want=0", bus.grant_id); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    bus.enable = 1'b1;
    bus.req_a = (NR*SA)'($urandom);
    bus.req_d = (NR*SD)'($urandom);
    bus.req_a[SA-1:0] = 7'h7F;
    bus.req_d[SD-1:0] = 8'hFF;
    bus.req = 4'b0001;
    for (int n = 1; n <= 24; n++) begin
      step();
      total++; if (bus.go !== exp_go) begin bad++; $display("FAIL single_go n=%0d got=%0b want=%0b", n, bus.go, exp_go); end
      total++; if (bus.frame_done !== exp_fd) begin bad++; $display("FAIL single_fd n=%0d got=%0b want=%0b", n, bus.frame_done, exp_fd); end
      if (n == 1) begin
        total++; if (bus.go !== 1'b1) begin bad++; $display("FAIL single_go1 got=%0b want=1", bus.go); end
        total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b want=0001", bus.ack); end
        total++; if (bus.a_out !== 7'h7F) begin bad++; $display("FAIL single_a got=%h want=7f", bus.a_out); end
        total++; if (bus.d_out !== 8'hFF) begin bad++; $display("FAIL single_d got=%h want=ff", bus.d_out); end
        bus.req = '0;
      end
      if (n == 21) begin
        total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL single_fd21 got=%0b want=1", bus.frame_done); end
      end
      if (n == 22) begin
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy22 got=%0b want=1", bus.busy); end
      end
      if (n == 23) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle23 got=%0b want=0", bus.busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    int gids[$];
    int gcyc[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    pulse_reset();
    bus.enable = 1'b1;
    bus.req = 4'b1111;
    for (int n = 0; n < 4 * PERIOD + 4; n++) begin
      step();
      if (bus.go === 1'b1) begin
        gids.push_back(int'(bus.grant_id));
        gcyc.push_back(cyc);
      end
      total++; if (bus.ack !== exp_ack) begin bad++; $display("FAIL rr_ack cyc=%0d got=%b want=%b", cyc, bus.ack, exp_ack); end
    end
    total++; if (gids.size() != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", gids.size()); end
    for (int i = 0; i < gids.size() && i < 5; i++) begin
      total++; if (gids[i] != exp_order[i]) begin bad++; $display("FAIL rr_order i=%0d got=%0d want=%0d", i, gids[i], exp_order[i]); end
      if (i > 0) begin
        total++; if (gcyc[i] - gcyc[i-1] != PERIOD) begin bad++;
          $display("FAIL rr_spacing i=%0d got=%0d want=%0d", i, gcyc[i] - gcyc[i-1], PERIOD); end
      end
    end
  endtask

  task automatic test_hold_capture();
    pulse_reset();
    bus.enable = 1'b1;
    bus.req = 4'b1000;
    for (int n = 0; n < PERIOD; n++) begin
      step();
      if (bus.ack[3]) bus.req = '0;
    end
    bus.req_a[2*SA +: SA] = 7'h41;
    bus.req_d[2*SD +: SD] = 8'h9F;
    bus.req = 4'b0100;
    step();
    total++; if (bus.go !== 1'b1) begin bad++; $display("FAIL hold_go got=%0b want=1", bus.go); end
    total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL hold_gid got=%0d want=2", bus.grant_id); end
    bus.req = '0;
    for (int n = 0; n < FL + 1; n++) begin
      bus.req_a = (NR*SA)'($urandom);
      bus.req_d = (NR*SD)'($urandom);
      step();
      total++; if (bus.a_out !== 7'h41) begin bad++; $display("FAIL hold_a n=%0d got=%h want=41", n, bus.a_out); end
      total++; if (bus.d_out !== 8'h9F) begin bad++; $display("FAIL hold_d n=%0d got=%h want=9f", n, bus.d_out); end
    end
  endtask

  task automatic test_enable();
    int fd_cnt;
    fd_cnt = 0;
    pulse_reset();
    bus.enable = 1'b1;
    bus.req = 4'b1111;
    step();
    total++; if (bus.go !== 1'b1) begin bad++; $display("FAIL en_go0 got=%0b want=1", bus.go); end
    repeat (6) step();
    bus.enable = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.frame_done === 1'b1) fd_cnt++;
      total++; if (bus.go !== 1'b0) begin bad++; $display("FAIL en_nogo n=%0d got=%0b want=0", n, bus.go); end
      total++; if (bus.frame_done !== exp_fd) begin bad++; $display("FAIL en_fd n=%0d got=%0b want=%0b", n, bus.frame_done, exp_fd); end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL en_fdcount got=%0d want=1", fd_cnt); end
    bus.enable = 1'b1;
    step();
    total++; if (bus.go !== 1'b1) begin bad++; $display("FAIL en_resume got=%0b want=1", bus.go); end
    total++; if (bus.ack !== 4'b0010) begin bad++; $display("FAIL en_ack got=%b want=0010", bus.ack); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bus.enable = 1'b1;
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    repeat (10) step();
    #2;
    reset = 1'b1;
    #1;
    total++; if ({bus.busy, bus.go, bus.ack} !== '0) begin bad++;
      $display("FAIL rstmid_ctrl got busy=%0b go=%0b ack=%b want 0", bus.busy, bus.go, bus.ack); end
    total++; if (bus.grant_id !== '0 || bus.a_out !== '0) begin bad++;
      $display("FAIL rstmid_data got gid=%0d a=%h want 0", bus.grant_id, bus.a_out); end
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    model_reset();
    bus.req = 4'b1111;
    step();
    total++; if (bus.go !== 1'b1) begin bad++; $display("FAIL rstmid_go got=%0b want=1", bus.go); end
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL rstmid_ack got=%b want=0001", bus.ack); end
    total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL rstmid_gid got=%0d want=0", bus.grant_id); end
  endtask

  task automatic test_withdraw();
    int go_cnt;
    go_cnt = 0;
    pulse_reset();
    bus.enable = 1'b1;
    bus.req = 4'b0010;
    for (int n = 1; n <= 32; n++) begin
      step();
      if (bus.go === 1'b1) go_cnt++;
      total++; if (bus.go !== exp_go) begin bad++; $display("FAIL wd_go n=%0d got=%0b want=%0b", n, bus.go, exp_go); end
      if (exp_fd) bus.req = '0;
    end
    total++; if (go_cnt != 1) begin bad++; $display("FAIL wd_gocount got=%0d want=1", go_cnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wd_idle got=%0b want=0", bus.busy); end
  endtask

  task automatic test_random();
    logic [NR-1:0] r;
    pulse_reset();
    bus.req = '0;
    for (int n = 0; n < 800; n++) begin
      step();
      total++; if (bus.go !== exp_go) begin bad++; $display("FAIL rnd_go cyc=%0d got=%0b want=%0b", cyc, bus.go, exp_go); end
      total++; if (bus.ack !== exp_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", cyc, bus.ack, exp_ack); end
      total++; if (bus.frame_done !== exp_fd) begin bad++; $display("FAIL rnd_fd cyc=%0d got=%0b want=%0b", cyc, bus.frame_done, exp_fd); end
      total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b want=%0b", cyc, bus.busy, exp_busy); end
      total++; if (bus.a_out !== m_a) begin bad++; $display("FAIL rnd_a cyc=%0d got=%h want=%h", cyc, bus.a_out, m_a); end
      total++; if (bus.d_out !== m_d) begin bad++; $display("FAIL rnd_d cyc=%0d got=%h want=%h", cyc, bus.d_out, m_d); end
      total++; if (int'(bus.grant_id) != m_win) begin bad++; $display("FAIL rnd_gid cyc=%0d got=%0d want=%0d", cyc, bus.grant_id, m_win); end
      r = bus.req;
      for (int i = 0; i < NR; i++) begin
        if (r[i] && bus.ack[i]) begin
          r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(3) == 0) begin
          r[i] = 1'b1;
          bus.req_a[i*SA +: SA] = SA'($urandom);
          bus.req_d[i*SD +: SD] = SD'($urandom);
        end
      end
      bus.req = r;
      bus.enable = ($urandom_range(7) != 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_hold_capture();
    test_enable();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
